// File: rtl/led_cube_pkg.sv
// Shared state codes and timeout constants for the LED-cube control path.
package led_cube_pkg;

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_GET_POS   = 3'd2;
    localparam logic [2:0] ST_GET_COL   = 3'd3;
    localparam logic [2:0] ST_ANIM      = 3'd4;
    localparam logic [2:0] ST_PAUSED    = 3'd5;

    localparam int TIMEOUT_DEFAULT = 50_000_000;
    localparam int TIMEOUT_SIM     = 16;

endpackage

// File: rtl/led_cube_ctrl_btn_edge.sv
// Button conditioner: 2-FF synchronizer, delay flop and rising-edge detector
// producing a single-cycle press pulse per press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic sync1, sync2, dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign press = sync2 & ~dly;

endmodule

// File: rtl/led_cube_ctrl.sv
// Mode-strobe FSM for the LED-cube datapath with selection inactivity timeout
// and random-colour latch for the animation stage.
module led_cube_ctrl
    import led_cube_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       load_btn,
    input  logic       pause_btn,
    input  logic       CDADone,
    input  logic       rcm,
    output logic       off,
    output logic       CDA,
    output logic       Pos,
    output logic       choC,
    output logic       AnS,
    output logic       pause,
    output logic       anim_rand,
    output logic [2:0] state_o
);

    localparam int              CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

    logic          start_press, load_press, pause_press;
    logic [2:0]    state, next_state;
    logic [CW-1:0] cnt;
    logic          timeout, sel_next;

    btn_edge u_start (.clk(clk), .reset(reset), .btn(start_btn), .press(start_press));
    btn_edge u_load  (.clk(clk), .reset(reset), .btn(load_btn),  .press(load_press));
    btn_edge u_pause (.clk(clk), .reset(reset), .btn(pause_btn), .press(pause_press));

    assign timeout = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_OFF;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_OFF:       if (start_press) next_state = ST_COUNTDOWN;
            ST_COUNTDOWN: if (CDADone)     next_state = ST_GET_POS;
            ST_GET_POS: begin
                if (load_press)   next_state = ST_GET_COL;
                else if (timeout) next_state = ST_OFF;
            end
            ST_GET_COL: begin
                if (load_press)   next_state = ST_ANIM;
                else if (timeout) next_state = ST_OFF;
            end
            ST_ANIM: begin
                if (start_press)      next_state = ST_GET_POS;
                else if (pause_press) next_state = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (start_press)      next_state = ST_GET_POS;
                else if (pause_press) next_state = ST_ANIM;
            end
            default:      next_state = ST_OFF;
        endcase
    end

    always_comb begin
        off   = 1'b0;
        CDA   = 1'b0;
        Pos   = 1'b0;
        choC  = 1'b0;
        AnS   = 1'b0;
        pause = 1'b0;
        case (state)
            ST_OFF:       off  = 1'b1;
            ST_COUNTDOWN: CDA  = 1'b1;
            ST_GET_POS:   Pos  = 1'b1;
            ST_GET_COL:   choC = 1'b1;
            ST_ANIM:      AnS  = 1'b1;
            ST_PAUSED: begin
                AnS   = 1'b1;
                pause = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o  = state;
    assign sel_next = (next_state == ST_GET_POS) || (next_state == ST_GET_COL);

    // Counter restarts on entering a selection state or on a load press; the FSM
    // leaves at LAST, so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!sel_next || (next_state != state) || load_press)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            anim_rand <= 1'b0;
        else if (state == ST_GET_COL && load_press)
            anim_rand <= rcm;
    end

endmodule

// File: tb/tb_led_cube_ctrl.sv
// Directed bench for led_cube_ctrl with a queue of expected states/flags.
module tb_led_cube_ctrl;
    import led_cube_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_btn = 1'b0, load_btn = 1'b0, pause_btn = 1'b0;
    logic       CDADone = 1'b0, rcm = 1'b0;
    logic       off, CDA, Pos, choC, AnS, pause, anim_rand;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       ar;
    } exp_t;

    exp_t sb[$];

    led_cube_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_SIM)) dut (
        .clk(clk), .reset(reset),
        .start_btn(start_btn), .load_btn(load_btn), .pause_btn(pause_btn),
        .CDADone(CDADone), .rcm(rcm),
        .off(off), .CDA(CDA), .Pos(Pos), .choC(choC), .AnS(AnS), .pause(pause),
        .anim_rand(anim_rand), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Strobe vector {off,CDA,Pos,choC,AnS,pause} expected for a state code.
    function automatic logic [5:0] strobes_for(input logic [2:0] st);
        case (st)
            3'd0:    return 6'b100000;
            3'd1:    return 6'b010000;
            3'd2:    return 6'b001000;
            3'd3:    return 6'b000100;
            3'd4:    return 6'b000010;
            3'd5:    return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic want(input string tag, input logic [2:0] st, input logic ar);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ar  = ar;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t       e;
        logic [5:0] obs;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed state %0d, expected an entry", state_o);
        end
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {off, CDA, Pos, choC, AnS, pause};
            checks += 2;
            assert (state_o === e.st) else begin
                errors++;
                $error("FAIL %s state: observed %0d expected %0d", e.tag, state_o, e.st);
            end
            assert (obs === strobes_for(e.st)) else begin
                errors++;
                $error("FAIL %s strobes: observed %b expected %b", e.tag, obs, strobes_for(e.st));
            end
            assert (anim_rand === e.ar) else begin
                errors++;
                $error("FAIL %s anim_rand: observed %b expected %b", e.tag, anim_rand, e.ar);
            end
        end
    endtask

    // One-sample button press; returns just after the edge where the state moves.
    task automatic press(input logic s, input logic l, input logic p);
        start_btn = s; load_btn = l; pause_btn = p;
        tick(1);
        start_btn = 1'b0; load_btn = 1'b0; pause_btn = 1'b0;
        tick(2);
    endtask

    task automatic cda_pulse();
        CDADone = 1'b1;
        tick(1);
        CDADone = 1'b0;
    endtask

    initial begin
        tick(2);
        want("reset", ST_OFF, 1'b0); check();
        reset = 1'b0;

        CDADone = 1'b1; tick(2); CDADone = 1'b0;
        want("cdadone_in_off", ST_OFF, 1'b0); check();

        // start press: strobes change two cycles after the first sample
        start_btn = 1'b1; tick(2);
        want("start_latency_early", ST_OFF, 1'b0); check();
        start_btn = 1'b0; tick(1);
        want("start_to_countdown", ST_COUNTDOWN, 1'b0); check();

        press(1'b1, 1'b0, 1'b1); tick(2);
        want("start_in_countdown", ST_COUNTDOWN, 1'b0); check();

        cda_pulse();
        want("cdadone_to_getpos", ST_GET_POS, 1'b0); check();
        tick(15);
        want("timeout_not_yet", ST_GET_POS, 1'b0); check();
        tick(1);
        want("timeout_to_off", ST_OFF, 1'b0); check();

        // load press arriving while the count sits at its last value
        press(1'b1, 1'b0, 1'b0);
        cda_pulse();
        want("getpos_again", ST_GET_POS, 1'b0); check();
        tick(13);
        press(1'b0, 1'b1, 1'b0);
        want("load_beats_timeout", ST_GET_COL, 1'b0); check();

        rcm = 1'b1;
        press(1'b0, 1'b1, 1'b0);
        rcm = 1'b0;
        want("load_to_anim_rcm1", ST_ANIM, 1'b1); check();

        press(1'b0, 1'b0, 1'b1);
        want("pause_in_anim", ST_PAUSED, 1'b1); check();
        press(1'b0, 1'b0, 1'b1);
        want("pause_resume", ST_ANIM, 1'b1); check();
        press(1'b0, 1'b0, 1'b1);
        want("pause_again", ST_PAUSED, 1'b1); check();
        press(1'b1, 1'b0, 1'b1);
        want("start_beats_pause", ST_GET_POS, 1'b1); check();

        // held load: one transition, then GET_COL times out
        load_btn = 1'b1;
        tick(3);
        want("held_load_to_getcol", ST_GET_COL, 1'b1); check();
        tick(15);
        want("held_getcol_waiting", ST_GET_COL, 1'b1); check();
        tick(1);
        want("held_getcol_timeout", ST_OFF, 1'b1); check();
        tick(81);
        load_btn = 1'b0;
        want("held_off_stays", ST_OFF, 1'b1); check();
        tick(2);

        press(1'b1, 1'b0, 1'b0);
        cda_pulse();
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        want("anim_rcm0", ST_ANIM, 1'b0); check();
        press(1'b1, 1'b0, 1'b0);
        want("start_in_anim", ST_GET_POS, 1'b0); check();
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        want("anim_before_reset", ST_ANIM, 1'b0); check();

        // asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1 want("async_reset", ST_OFF, 1'b0); check();
        tick(2);
        reset = 1'b0;
        tick(1);

        #1 force dut.state = 3'd7;
        #1 release dut.state;
        want("illegal_code_seen", 3'd7, 1'b0); check();
        tick(1);
        want("illegal_recover", ST_OFF, 1'b0); check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
